// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two requesters.
// Operands are registered and held for SETTLE cycles, then d/flags are returned on a tagged response port.
module alu_share_arbiter #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_s,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_s,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_d,
    output logic             rsp_cout,
    output logic             rsp_v,
    output logic             rsp_err,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_s,
    output logic             alu_cin,
    input  logic [WIDTH-1:0] alu_d,
    input  logic             alu_cout,
    input  logic             alu_v,
    output logic             busy
);

    localparam int unsigned CNT_W = 4;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_ILL  = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               last_grant_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               grant_c;
    logic               accept_c;
    logic               settle_done_c;
    logic [2:0]         sel_s_c;
    logic [WIDTH-1:0]   sel_a_c;
    logic [WIDTH-1:0]   sel_b_c;
    logic               sel_cin_c;

    // Round-robin pick: alternate on contention, otherwise serve whoever is valid.
    always_comb begin
        grant_c = req1_valid;
        if (req0_valid && req1_valid) begin
            grant_c = ~last_grant_q;
        end
    end

    assign req0_ready    = (state_q == IDLE) && req0_valid && !grant_c;
    assign req1_ready    = (state_q == IDLE) && req1_valid && grant_c;
    assign accept_c      = req0_ready || req1_ready;
    assign settle_done_c = (state_q == EXEC) && (cnt_q == CNT_W'(1));

    always_comb begin
        sel_s_c   = req0_s;
        sel_a_c   = req0_a;
        sel_b_c   = req0_b;
        sel_cin_c = req0_cin;
        if (grant_c) begin
            sel_s_c   = req1_s;
            sel_a_c   = req1_a;
            sel_b_c   = req1_b;
            sel_cin_c = req1_cin;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    state_d = (sel_s_c == OP_ILL) ? RESP : EXEC;
                end
            end
            EXEC: begin
                if (settle_done_c) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand/result datapath; ALU inputs move only on an accepted legal op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            rsp_id       <= 1'b0;
            rsp_d        <= '0;
            rsp_cout     <= 1'b0;
            rsp_v        <= 1'b0;
            rsp_err      <= 1'b0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_s        <= OP_OR;
            alu_cin      <= 1'b0;
        end else begin
            if (accept_c) begin
                last_grant_q <= grant_c;
                rsp_id       <= grant_c;
                cnt_q        <= CNT_W'(SETTLE);
                if (sel_s_c == OP_ILL) begin
                    rsp_d    <= '0;
                    rsp_cout <= 1'b0;
                    rsp_v    <= 1'b0;
                    rsp_err  <= 1'b1;
                end else begin
                    alu_a   <= sel_a_c;
                    alu_b   <= sel_b_c;
                    alu_s   <= sel_s_c;
                    alu_cin <= sel_cin_c;
                end
            end
            if (state_q == EXEC) begin
                cnt_q <= cnt_q - CNT_W'(1);
                if (settle_done_c) begin
                    rsp_d   <= alu_d;
                    rsp_err <= 1'b0;
                    // Flags are only meaningful for the arithmetic opcodes.
                    if ((alu_s == OP_ADD) || (alu_s == OP_SUB)) begin
                        rsp_cout <= alu_cout;
                        rsp_v    <= alu_v;
                    end else begin
                        rsp_cout <= 1'b0;
                        rsp_v    <= 1'b0;
                    end
                end
            end
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: instance 0 uses SETTLE=1, instance 1 uses SETTLE=3.
// A transaction-level model is compared every cycle; directed tests add literal expectations.
module tb_alu_share_arbiter;

    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         r0v [2];
    logic         r0r [2];
    logic [2:0]   r0s [2];
    logic [W-1:0] r0a [2];
    logic [W-1:0] r0b [2];
    logic         r0c [2];
    logic         r1v [2];
    logic         r1r [2];
    logic [2:0]   r1s [2];
    logic [W-1:0] r1a [2];
    logic [W-1:0] r1b [2];
    logic         r1c [2];
    logic         rsp_valid [2];
    logic         rsp_ready [2];
    logic         rsp_id [2];
    logic [W-1:0] rsp_d [2];
    logic         rsp_cout [2];
    logic         rsp_v [2];
    logic         rsp_err [2];
    logic [W-1:0] alu_a [2];
    logic [W-1:0] alu_b [2];
    logic [2:0]   alu_s [2];
    logic         alu_cin [2];
    logic         busy [2];

    int n_chk = 0;
    int n_fail = 0;

    // Reference ALU: {v, cout, d}
    function automatic logic [33:0] alu_fn(input logic [2:0] s, input logic [31:0] a,
                                           input logic [31:0] b, input logic cin);
        logic [32:0] sum;
        logic [31:0] bb;
        logic        ov;
        case (s)
            3'b000: return {2'b00, a ^ b};
            3'b001: return {2'b00, ~(a ^ b)};
            3'b010, 3'b011: begin
                bb  = (s == 3'b011) ? ~b : b;
                sum = {1'b0, a} + {1'b0, bb} + 33'(cin);
                ov  = (a[31] == bb[31]) && (sum[31] != a[31]);
                return {ov, sum[32], sum[31:0]};
            end
            3'b100: return {2'b00, a | b};
            3'b101: return {2'b00, ~(a | b)};
            3'b110: return {2'b00, a & b};
            default: return 34'd0;
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [W-1:0] d_w;
        logic         cout_w;
        logic         v_w;

        alu_share_arbiter #(.WIDTH(W), .SETTLE(g == 0 ? 1 : 3)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .req0_valid(r0v[g]), .req0_ready(r0r[g]), .req0_s(r0s[g]),
            .req0_a(r0a[g]), .req0_b(r0b[g]), .req0_cin(r0c[g]),
            .req1_valid(r1v[g]), .req1_ready(r1r[g]), .req1_s(r1s[g]),
            .req1_a(r1a[g]), .req1_b(r1b[g]), .req1_cin(r1c[g]),
            .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]), .rsp_id(rsp_id[g]),
            .rsp_d(rsp_d[g]), .rsp_cout(rsp_cout[g]), .rsp_v(rsp_v[g]), .rsp_err(rsp_err[g]),
            .alu_a(alu_a[g]), .alu_b(alu_b[g]), .alu_s(alu_s[g]), .alu_cin(alu_cin[g]),
            .alu_d(d_w), .alu_cout(cout_w), .alu_v(v_w),
            .busy(busy[g])
        );

        // Combinational ALU; logic ops drive junk flags so flag masking is observable.
        always_comb begin
            logic [33:0] r;
            r = alu_fn(alu_s[g], alu_a[g], alu_b[g], alu_cin[g]);
            d_w = r[31:0];
            if (alu_s[g] == 3'b010 || alu_s[g] == 3'b011) begin
                cout_w = r[32];
                v_w    = r[33];
            end else begin
                cout_w = ~^alu_a[g];
                v_w    = 1'b1;
            end
        end
    end

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] at %0t: got %h expected %h", name, i, $time, act, exp);
        end
    endtask

    task automatic chk1(input string name, input int i, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] at %0t: got %b expected %b", name, i, $time, act, exp);
        end
    endtask

    // Transaction-level model state per instance
    bit          m_busy [2];
    bit          m_last [2];
    int          m_left [2];
    logic        m_id [2];
    logic [2:0]  m_s [2];
    logic [31:0] m_a [2];
    logic [31:0] m_b [2];
    logic        m_c [2];
    logic [31:0] e_a [2];
    logic [31:0] e_b [2];
    logic [2:0]  e_s [2];
    logic        e_c [2];

    task automatic model_reset(input int i);
        m_busy[i] = 1'b0;
        m_last[i] = 1'b1;
        m_left[i] = 0;
        e_a[i] = '0;
        e_b[i] = '0;
        e_s[i] = 3'b100;
        e_c[i] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) model_reset(i);
    end

    // Per-cycle compare, then advance the model across the next rising edge.
    always @(negedge clk) begin : compare
        logic        pick;
        logic        er0;
        logic        er1;
        logic        ev;
        logic [33:0] r;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                model_reset(i);
                chk1("rst_rsp_valid", i, rsp_valid[i], 1'b0);
                chk1("rst_busy", i, busy[i], 1'b0);
                chk("rst_alu_s", i, 32'(alu_s[i]), 32'h4);
            end else begin
                pick = (r0v[i] && r1v[i]) ? !m_last[i] : r1v[i];
                er0  = !m_busy[i] && r0v[i] && !pick;
                er1  = !m_busy[i] && r1v[i] && pick;
                ev   = m_busy[i] && (m_left[i] == 0);
                chk1("req0_ready", i, r0r[i], er0);
                chk1("req1_ready", i, r1r[i], er1);
                chk1("busy", i, busy[i], m_busy[i]);
                chk1("rsp_valid", i, rsp_valid[i], ev);
                chk("alu_a", i, alu_a[i], e_a[i]);
                chk("alu_b", i, alu_b[i], e_b[i]);
                chk("alu_s", i, 32'(alu_s[i]), 32'(e_s[i]));
                chk1("alu_cin", i, alu_cin[i], e_c[i]);
                if (ev) begin
                    r = alu_fn(m_s[i], m_a[i], m_b[i], m_c[i]);
                    chk1("rsp_id", i, rsp_id[i], m_id[i]);
                    chk1("rsp_err", i, rsp_err[i], m_s[i] == 3'b111);
                    chk("rsp_d", i, rsp_d[i], (m_s[i] == 3'b111) ? 32'h0 : r[31:0]);
                    chk1("rsp_cout", i, rsp_cout[i], (m_s[i] == 3'b010 || m_s[i] == 3'b011) ? r[32] : 1'b0);
                    chk1("rsp_v", i, rsp_v[i], (m_s[i] == 3'b010 || m_s[i] == 3'b011) ? r[33] : 1'b0);
                end
                if (m_busy[i]) begin
                    if (m_left[i] == 0) begin
                        if (rsp_ready[i]) m_busy[i] = 1'b0;
                    end else begin
                        m_left[i]--;
                    end
                end else if (er0 || er1) begin
                    m_s[i] = pick ? r1s[i] : r0s[i];
                    m_a[i] = pick ? r1a[i] : r0a[i];
                    m_b[i] = pick ? r1b[i] : r0b[i];
                    m_c[i] = pick ? r1c[i] : r0c[i];
                    m_id[i] = pick;
                    m_last[i] = pick;
                    m_busy[i] = 1'b1;
                    if (m_s[i] == 3'b111) begin
                        m_left[i] = 0;
                    end else begin
                        m_left[i] = (i == 0) ? 1 : 3;
                        e_a[i] = m_a[i];
                        e_b[i] = m_b[i];
                        e_s[i] = m_s[i];
                        e_c[i] = m_c[i];
                    end
                end
            end
        end
    end

    task automatic set_req(input int i, input int n, input logic vld, input logic [2:0] s,
                           input logic [31:0] a, input logic [31:0] b, input logic cin);
        if (n == 0) begin
            r0v[i] = vld; r0s[i] = s; r0a[i] = a; r0b[i] = b; r0c[i] = cin;
        end else begin
            r1v[i] = vld; r1s[i] = s; r1a[i] = a; r1b[i] = b; r1c[i] = cin;
        end
    endtask

    // Present one op and hold it until accepted; returns just after the accept edge.
    task automatic issue(input int i, input int n, input logic [2:0] s,
                         input logic [31:0] a, input logic [31:0] b, input logic cin);
        int k;
        logic rdy;
        set_req(i, n, 1'b1, s, a, b, cin);
        k = 0;
        @(negedge clk);
        rdy = (n == 0) ? r0r[i] : r1r[i];
        while (!rdy && k < 20) begin
            @(negedge clk);
            rdy = (n == 0) ? r0r[i] : r1r[i];
            k++;
        end
        chk1("accept_timeout", i, rdy, 1'b1);
        @(posedge clk);
        #1;
        if (n == 0) r0v[i] = 1'b0; else r1v[i] = 1'b0;
    endtask

    // Wait for a response, check literals, hold it `hold` cycles, then take it.
    task automatic wait_rsp(input int i, input logic id, input logic [31:0] d, input logic co,
                            input logic vv, input logic er, input int hold, input bit drop,
                            output int lat);
        int k;
        k = 0;
        @(negedge clk);
        while (!rsp_valid[i] && k < 40) begin
            @(negedge clk);
            k++;
        end
        lat = k;
        chk1("rsp_timeout", i, rsp_valid[i], 1'b1);
        chk1("lit_id", i, rsp_id[i], id);
        chk("lit_d", i, rsp_d[i], d);
        chk1("lit_cout", i, rsp_cout[i], co);
        chk1("lit_v", i, rsp_v[i], vv);
        chk1("lit_err", i, rsp_err[i], er);
        for (int h = 0; h < hold; h++) @(negedge clk);
        chk("lit_hold_d", i, rsp_d[i], d);
        chk1("lit_hold_busy", i, busy[i], 1'b1);
        @(posedge clk);
        #1;
        rsp_ready[i] = 1'b1;
        if (drop) begin
            r0v[i] = 1'b0;
            r1v[i] = 1'b0;
        end
        @(posedge clk);
        #1;
        rsp_ready[i] = 1'b0;
        chk1("lit_idle_after_rsp", i, busy[i], 1'b0);
    endtask

    initial begin : stim
        int lat;
        for (int i = 0; i < 2; i++) begin
            rsp_ready[i] = 1'b0;
            set_req(i, 0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
            set_req(i, 1, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            chk1("reset_rsp_id", i, rsp_id[i], 1'b0);
            chk("reset_rsp_d", i, rsp_d[i], 32'h0);
            chk1("reset_rsp_err", i, rsp_err[i], 1'b0);
            chk1("reset_rsp_cout", i, rsp_cout[i], 1'b0);
            chk("reset_alu_a", i, alu_a[i], 32'h0);
            chk("reset_alu_s", i, 32'(alu_s[i]), 32'h4);
        end

        // Stray rsp_ready while idle must do nothing
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[0] = 1'b0;

        // 1: single add, SETTLE=1
        issue(0, 0, 3'b010, 32'h7FFFFFFF, 32'h0, 1'b1);
        wait_rsp(0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, 0, 1'b0, lat);
        chk("lat_add", 0, 32'(lat), 32'd1);

        // 2: sub with 5 cycles of backpressure
        issue(0, 1, 3'b011, 32'h31312020, 32'hCCEEDDFF, 1'b1);
        wait_rsp(0, 1'b1, 32'h64424221, 1'b0, 1'b0, 1'b0, 5, 1'b0, lat);

        // 3: contention, grants alternate 0,1,0,1
        set_req(0, 0, 1'b1, 3'b110, 32'hFFFFFFFF, 32'h0000FFFF, 1'b0);
        set_req(0, 1, 1'b1, 3'b100, 32'hF101CBA9, 32'h0011ADC1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            if (k[0] == 1'b0)
                wait_rsp(0, 1'b0, 32'h0000FFFF, 1'b0, 1'b0, 1'b0, 0, k == 3, lat);
            else
                wait_rsp(0, 1'b1, 32'hF111EFE9, 1'b0, 1'b0, 1'b0, 0, k == 3, lat);
        end

        // 4: xor then illegal opcode
        issue(0, 0, 3'b000, 32'hF01010CA, 32'h0F0F0F0F, 1'b0);
        wait_rsp(0, 1'b0, 32'hFF1F1FC5, 1'b0, 1'b0, 1'b0, 0, 1'b0, lat);
        issue(0, 0, 3'b111, 32'h12345678, 32'h9ABCDEF0, 1'b1);
        wait_rsp(0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1, 1'b0, lat);
        chk("lat_illegal", 0, 32'(lat), 32'd0);
        chk("illegal_alu_a", 0, alu_a[0], 32'hF01010CA);
        chk("illegal_alu_s", 0, 32'(alu_s[0]), 32'h0);

        // 5: SETTLE=3 carry chain
        issue(1, 0, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        wait_rsp(1, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0, 0, 1'b0, lat);
        chk("lat_settle3", 1, 32'(lat), 32'd3);

        // 6: reset during the second EXEC cycle
        issue(1, 1, 3'b010, 32'h00000005, 32'h00000006, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk1("async_busy", 1, busy[1], 1'b0);
        chk1("async_rsp_valid", 1, rsp_valid[1], 1'b0);
        chk("async_rsp_d", 1, rsp_d[1], 32'h0);
        chk("async_alu_a", 1, alu_a[1], 32'h0);
        chk("async_alu_s", 1, 32'(alu_s[1]), 32'h4);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        set_req(1, 0, 1'b1, 3'b000, 32'h00000001, 32'h00000003, 1'b0);
        set_req(1, 1, 1'b1, 3'b110, 32'hFFFF0000, 32'h12345678, 1'b0);
        wait_rsp(1, 1'b0, 32'h00000002, 1'b0, 1'b0, 1'b0, 0, 1'b1, lat);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single 32-bit combinational ALU (opcode S[2:0], Cin, Cout, V) between two requesters.
- Each requester has a valid/ready request port. The block arbitrates round-robin, registers the operands, drives the ALU, and waits a fixed settle time.
- After the settle time it captures d/Cout/V and returns the result on one shared response port tagged with the requester id.
- Sits between the issue logic and the ALU instance; it is the only driver of the ALU inputs.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU.
- SETTLE, 1, clock cycles ALU inputs are held stable before outputs are sampled; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_s  in  3  requester 0 ALU opcode
- req0_a, req0_b  in  WIDTH  requester 0 operands
- req0_cin  in  1  requester 0 carry-in
- req1_valid, req1_ready, req1_s, req1_a, req1_b, req1_cin  same as above, for requester 1
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes response
- rsp_id  out  1  requester that issued the op
- rsp_d  out  WIDTH  result
- rsp_cout  out  1  carry-out
- rsp_v  out  1  overflow
- rsp_err  out  1  illegal opcode (3'b111)
- alu_a, alu_b  out  WIDTH  ALU operands
- alu_s  out  3  ALU opcode
- alu_cin  out  1  ALU carry-in
- alu_d  in  WIDTH  ALU result
- alu_cout, alu_v  in  1  ALU flags
- busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - state = IDLE; last_grant = 1, so requester 0 wins first.
  - rsp_valid = 0; rsp_id, rsp_d, rsp_cout, rsp_v, rsp_err = 0.
  - alu_a = alu_b = 0; alu_s = 3'b100; alu_cin = 0.
- Opcodes (ALU contract):
  - 000 xor, 001 xnor, 010 add a+b+cin, 011 sub a+~b+cin, 100 or, 101 nor, 110 and, 111 illegal.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant selection: if both valid, grant = ~last_grant; else grant = the valid requester.
  - reqN_ready is combinational: (state==IDLE) && reqN_valid && (grant==N). At most one ready per cycle.
  - On accept edge: latch s/a/b/cin into alu_* registers; last_grant = N; rsp_id = N; cnt = SETTLE.
  - Legal op: go to EXEC.
  - Opcode 111: do not touch alu_* (hold previous values); rsp_d = 0, rsp_cout = 0, rsp_v = 0, rsp_err = 1; go directly to RESP.
- EXEC:
  - cnt decrements each cycle.
  - On the edge where cnt==1: rsp_d = alu_d; rsp_err = 0.
  - For S in {010, 011}: rsp_cout = alu_cout and rsp_v = alu_v. For all other opcodes, rsp_cout = rsp_v = 0.
  - Then go to RESP.
- Latency (legal op): accepted on edge E0, rsp_valid first high after edge E0+SETTLE. With SETTLE=1, the response is visible the cycle after acceptance.
- RESP:
  - rsp_valid = 1; all rsp_* held stable until rsp_valid && rsp_ready.
  - On that handshake edge go to IDLE; rsp_valid drops.
- No new acceptance in EXEC or RESP. A requester waiting during that time keeps valid high; its payload must be held stable until ready.
- Throughput: at most one op per SETTLE+2 cycles, since a single IDLE cycle is needed between ops.
- alu_* outputs change only on an accept edge. They hold their values in all other states, including IDLE, so the ALU sees no spurious toggling.
- Reset asserted mid-EXEC or mid-RESP: immediate return to reset values; the in-flight op is dropped and no response is issued.
- rsp_ready high when rsp_valid is low has no effect.
- Starvation bound: with both requesters continuously valid, grants strictly alternate 0,1,0,1,…

Test Plan:
1. Single add, SETTLE=1: req0 s=010, a=7FFFFFFF, b=0, cin=1.
   - Required: req0_ready high for 1 cycle.
   - Next cycle: rsp_valid=1, rsp_id=0, rsp_d=80000000, rsp_v=1, rsp_cout=0, rsp_err=0.
2. Sub with backpressure: req1 s=011, a=31312020, b=CCEEDDFF, cin=1; rsp_ready held low for 5 cycles.
   - Required: rsp_d=64424221, rsp_id=1, all rsp_* stable for those 5 cycles, busy=1.
   - Required: IDLE entered one edge after rsp_ready rises.
3. Contention: both valid continuously.
   - req0: s=110, a=FFFFFFFF, b=0000FFFF. req1: s=100, a=F101CBA9, b=0011ADC1.
   - Required: grants alternate 0,1,0,1; responses 0000FFFF (id0), F111EFE9 (id1); rsp_cout = rsp_v = 0 for both.
4. Illegal opcode: req0 s=111, preceded by a completed xor with alu_a=F01010CA.
   - Required: rsp_err=1, rsp_d=0 one cycle after accept; alu_a still F01010CA; no EXEC cycle.
5. SETTLE=3 carry chain: s=010, a=FFFFFFFF, b=FFFFFFFF, cin=0.
   - Required: rsp_valid first high 3 cycles after accept, rsp_d=FFFFFFFE, rsp_cout=1, rsp_v=0.
   - Required: alu_* unchanged throughout.
6. Reset mid-EXEC (SETTLE=3): drop rst_n on the 2nd EXEC cycle.
   - Required: outputs return to reset values asynchronously, and no rsp_valid pulse ever appears.
   - Required: the first grant after reset goes to req0.
